io_input_device: RTL and testbench

//  Memory-mapped responder for the board inputs (KEY, SW) on the processor data bus.

---
 rtl/io_map_pkg.sv | 50 +++++
 rtl/debounce_cell.sv | 53 +++++
 rtl/io_input_device.sv | 101 ++++++++++
 tb/tb_io_input_device.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared address map and control-register layout for the KEY/SW input device.
// Also provides the control-register update rule used by both input groups.
package io_map_pkg;

    localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
    localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    localparam int unsigned CTRL_RDY = 0;
    localparam int unsigned CTRL_OVR = 2;
    localparam int unsigned CTRL_IE  = 4;

    localparam int unsigned KEY_BITS = 4;
    localparam int unsigned SW_BITS  = 10;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w           = '0;
        w[CTRL_RDY] = c.rdy;
        w[CTRL_OVR] = c.ovr;
        w[CTRL_IE]  = c.ie;
        return w;
    endfunction

    // A change event outranks a read-clear in the same cycle and only overruns if RDY survives.
    function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic chg, input logic rd_clr,
                                        input logic wr, input logic wr_ie, input logic wr_keep_ovr);
        ctrl_t nxt;
        nxt = cur;
        if (wr) begin
            nxt.ie = wr_ie;
            if (!wr_keep_ovr) nxt.ovr = 1'b0;
        end
        if (chg) begin
            nxt.rdy = 1'b1;
            if (cur.rdy && !rd_clr) nxt.ovr = 1'b1;
        end else if (rd_clr) begin
            nxt.rdy = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a stability counter for one input bit.
// flip_c_o pulses in the cycle whose edge updates the stable bit.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_BITS        = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o,
    output logic flip_c_o
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                stable_q;
    logic                stable_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        flip_c_o = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                flip_c_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_input_device.sv
// Memory-mapped KEY/SW responder: debounced data registers, sticky RDY/OVR status,
// per-group interrupt enable, combinational read mux and interrupt request.
module io_input_device
    import io_map_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_BITS        = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    addr,
    input  logic                rdEn,
    input  logic                wrtEn,
    input  logic [DBITS-1:0]    dIn,
    input  logic [KEY_BITS-1:0] key,
    input  logic [SW_BITS-1:0]  sw,
    output logic                hit,
    output logic [DBITS-1:0]    dOut,
    output logic                irq
);

    logic [KEY_BITS-1:0] kstate;
    logic [KEY_BITS-1:0] kflip;
    logic [SW_BITS-1:0]  sstate;
    logic [SW_BITS-1:0]  sflip;
    ctrl_t               kctrl_q;
    ctrl_t               kctrl_d;
    ctrl_t               sctrl_q;
    ctrl_t               sctrl_d;
    logic                sel_kdata;
    logic                sel_sdata;
    logic                sel_kctrl;
    logic                sel_sctrl;
    logic                unused_din;

    // Keys are active-low pins; inverting ahead of the sync keeps idle keys at 0 through reset.
    for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (~key[i]),
            .stable_o (kstate[i]),
            .flip_c_o (kflip[i])
        );
    end

    for (genvar i = 0; i < SW_BITS; i++) begin : g_sw
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (sw[i]),
            .stable_o (sstate[i]),
            .flip_c_o (sflip[i])
        );
    end

    assign sel_kdata  = (addr == DBITS'(ADDR_KDATA));
    assign sel_sdata  = (addr == DBITS'(ADDR_SDATA));
    assign sel_kctrl  = (addr == DBITS'(ADDR_KCTRL));
    assign sel_sctrl  = (addr == DBITS'(ADDR_SCTRL));
    assign unused_din = ^{dIn[DBITS-1:5], dIn[3], dIn[1:0]};

    always_comb begin
        kctrl_d = ctrl_next(kctrl_q, |kflip, rdEn && sel_kdata, wrtEn && sel_kctrl,
                            dIn[CTRL_IE], dIn[CTRL_OVR]);
        sctrl_d = ctrl_next(sctrl_q, |sflip, rdEn && sel_sdata, wrtEn && sel_sctrl,
                            dIn[CTRL_IE], dIn[CTRL_OVR]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kctrl_q <= '0;
            sctrl_q <= '0;
        end else begin
            kctrl_q <= kctrl_d;
            sctrl_q <= sctrl_d;
        end
    end

    always_comb begin
        hit  = 1'b0;
        dOut = '0;
        if (sel_kdata) begin
            hit  = 1'b1;
            dOut = DBITS'(kstate);
        end else if (sel_sdata) begin
            hit  = 1'b1;
            dOut = DBITS'(sstate);
        end else if (sel_kctrl) begin
            hit  = 1'b1;
            dOut = DBITS'(ctrl_word(kctrl_q));
        end else if (sel_sctrl) begin
            hit  = 1'b1;
            dOut = DBITS'(ctrl_word(sctrl_q));
        end
    end

    assign irq = (kctrl_q.ie & kctrl_q.rdy) | (sctrl_q.ie & sctrl_q.rdy);

endmodule

// File: tb/tb_io_input_device.sv
// Directed bench for io_input_device with a short debounce window (4 cycles).
// Inputs change 1ns after a rising edge; registers are peeked with rdEn low.
module tb_io_input_device;
    import io_map_pkg::*;

    localparam int unsigned DBITS = 32;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [DBITS-1:0] addr  = '0;
    logic             rdEn  = 1'b0;
    logic             wrtEn = 1'b0;
    logic [DBITS-1:0] dIn   = '0;
    logic [3:0]       key   = 4'hF;
    logic [9:0]       sw    = '0;
    logic             hit;
    logic [DBITS-1:0] dOut;
    logic             irq;

    int tests = 0;
    int fails = 0;

    io_input_device #(.DBITS(DBITS), .DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .rdEn  (rdEn),
        .wrtEn (wrtEn),
        .dIn   (dIn),
        .key   (key),
        .sw    (sw),
        .hit   (hit),
        .dOut  (dOut),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rdEn  = 1'b0;
        wrtEn = 1'b0;
        #1;
        check(tag, dOut, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic rd_clear(input logic [31:0] a);
        addr = a;
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        dIn   = d;
        wrtEn = 1'b1;
        tick(1);
        wrtEn = 1'b0;
    endtask

    initial begin
        // Reset and idle state
        tick(3);
        reset = 1'b1;
        tick(20);
        chk_reg("rst_kdata", ADDR_KDATA, 32'h0);
        chk_reg("rst_sdata", ADDR_SDATA, 32'h0);
        chk_reg("rst_kctrl", ADDR_KCTRL, 32'h0);
        chk_reg("rst_sctrl", ADDR_SCTRL, 32'h0);
        chk_irq("rst_irq", 1'b0);
        tick(1);
        chk_reg("hit_kctrl", ADDR_KCTRL, 32'h0);
        check("hit_mapped", {31'b0, hit}, 32'h1);
        chk_reg("unmapped_dout", 32'hF000_0018, 32'h0);
        check("unmapped_hit", {31'b0, hit}, 32'h0);

        // key[1] press lands exactly six edges later
        tick(1);
        key = 4'b1101;
        tick(5);
        chk_reg("k1_edge5", ADDR_KDATA, 32'h0);
        tick(1);
        chk_reg("k1_edge6", ADDR_KDATA, 32'h2);
        chk_reg("k1_kctrl", ADDR_KCTRL, 32'h1);

        // Read returns pre-edge data and clears RDY
        addr = ADDR_KDATA;
        rdEn = 1'b1;
        #1;
        check("rd_pre_edge", dOut, 32'h2);
        tick(1);
        rdEn = 1'b0;
        chk_reg("rd_clr_kctrl", ADDR_KCTRL, 32'h0);

        // Three-cycle glitch on key[0] is filtered
        tick(1);
        key = 4'b1100;
        tick(3);
        key = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            chk_reg("glitch_kdata", ADDR_KDATA, 32'h2);
            tick(1);
        end
        chk_reg("glitch_kctrl", ADDR_KCTRL, 32'h0);

        // Two switch changes without a read overrun
        sw = 10'h001;
        tick(8);
        chk_reg("sw1_sdata", ADDR_SDATA, 32'h1);
        chk_reg("sw1_sctrl", ADDR_SCTRL, 32'h1);
        tick(1);
        sw = 10'h003;
        tick(8);
        chk_reg("sw2_sdata", ADDR_SDATA, 32'h3);
        chk_reg("sw2_sctrl", ADDR_SCTRL, 32'h5);
        wr(ADDR_SCTRL, 32'h4);
        chk_reg("ovr_keep", ADDR_SCTRL, 32'h5);
        wr(ADDR_SCTRL, 32'h0);
        chk_reg("ovr_clr", ADDR_SCTRL, 32'h1);

        // Release key[1], then clear status
        tick(1);
        key = 4'hF;
        tick(8);
        chk_reg("rel_kdata", ADDR_KDATA, 32'h0);
        chk_reg("rel_kctrl", ADDR_KCTRL, 32'h1);
        rd_clear(ADDR_KDATA);
        wr(ADDR_KDATA, 32'hFFFF_FFFF);
        chk_reg("wr_data_ign", ADDR_KDATA, 32'h0);

        // Interrupt enable and key[3] press
        wr(ADDR_KCTRL, 32'h10);
        chk_reg("ie_kctrl", ADDR_KCTRL, 32'h10);
        key = 4'b0111;
        tick(5);
        chk_irq("irq_before", 1'b0);
        tick(1);
        chk_reg("k3_kdata", ADDR_KDATA, 32'h8);
        chk_irq("irq_set", 1'b1);
        rd_clear(ADDR_KDATA);
        chk_irq("irq_clr", 1'b0);
        chk_reg("irq_clr_kctrl", ADDR_KCTRL, 32'h10);

        // Read-clear on the same edge a change lands
        tick(1);
        key = 4'hF;
        tick(5);
        addr = ADDR_KDATA;
        rdEn = 1'b1;
        #1;
        check("coll_pre", dOut, 32'h8);
        tick(1);
        rdEn = 1'b0;
        chk_reg("coll_kdata", ADDR_KDATA, 32'h0);
        chk_reg("coll_kctrl", ADDR_KCTRL, 32'h11);
        chk_irq("coll_irq", 1'b1);

        // Reset mid-debounce discards the pending key[2] press
        tick(1);
        key = 4'b1011;
        tick(4);
        reset = 1'b0;
        key   = 4'hF;
        sw    = '0;
        tick(3);
        chk_reg("mrst_kctrl", ADDR_KCTRL, 32'h0);
        chk_reg("mrst_sdata", ADDR_SDATA, 32'h0);
        reset = 1'b1;
        tick(12);
        chk_reg("post_kdata", ADDR_KDATA, 32'h0);
        chk_reg("post_kctrl", ADDR_KCTRL, 32'h0);
        chk_reg("post_sctrl", ADDR_SCTRL, 32'h0);
        chk_irq("post_irq", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
